tdm_demultiplex: RTL and testbench

//  Receive end of the 8:1 multiplexer path. Takes a time-division serial stream
//  (one bit per clock, slot i = channel i) plus a frame-sync strobe, steers each

---
 rtl/tdm_pkg.sv | 38 +++
 rtl/tdm_slot_counter.sv | 34 +++
 rtl/tdm_demultiplex.sv | 138 +++++++++++++
 tb/tb_tdm_demultiplex.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer slice: default channel count,
// FSM state encoding and the frame length (data slots plus optional parity slot).
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds an even-parity slot per frame).
package tdm_pkg;

  localparam int TDM_N     = 8;
  localparam int TDM_SEL_W = $clog2(TDM_N);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_t;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_FRAME_LEN = TDM_N + 1;
`else
  localparam int TDM_FRAME_LEN = TDM_N;
`endif

  // Counter width needed to address every slot of a frame of n data slots.
  function automatic int tdm_cnt_width(input int sel_w);
`ifdef TDM_DEMUX_PARITY_EN
    return sel_w + 1;
`else
    return sel_w;
`endif
  endfunction

  // Number of slots in one frame of n data channels.
  function automatic int tdm_frame_len(input int n);
`ifdef TDM_DEMUX_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer. Counts 0..LAST and wraps, can be
// forced to 1 (the slot after a sync-marked slot 0) or cleared to 0, and flags
// the terminal slot combinationally from the registered count.
module tdm_slot_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_one,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         terminal
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  // Slot index register: load-to-1 wins over clear, clear over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= (count == LAST_V) ? '0 : count + W'(1);
    end
  end

  assign terminal = (count == LAST_V);

endmodule

// File: rtl/tdm_demultiplex.sv
// Receive side of the 8:1 TDM link. Locks onto the frame-sync strobe, steers
// each serial bit into its channel position and publishes complete frames as a
// registered parallel word with a one-cycle frame_valid pulse.
// Optional feature macro: TDM_DEMUX_PARITY_EN -- each frame carries one extra
// even-parity slot; frames failing the check are dropped and flagged on parity_err.
module tdm_demultiplex
  import tdm_pkg::*;
#(
  parameter  int N         = TDM_N,
  parameter  int SEL_W     = $clog2(N),
  localparam int CNT_W     = tdm_cnt_width(SEL_W),
  localparam int FRAME_LEN = tdm_frame_len(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             din,
  output logic [N-1:0]     out,
  output logic             frame_valid,
  output logic [CNT_W-1:0] sel,
  output logic             locked
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  // With parity every data bit is staged; without it the last data bit goes
  // straight from din into out, so one fewer staging bit is needed.
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SHADOW_W = N;
`else
  localparam int SHADOW_W = N - 1;
`endif

  tdm_state_t          state;
  logic [SHADOW_W-1:0] shadow;
  logic [CNT_W-1:0]    count;
  logic                terminal;
  logic                slot_zero;
  logic [SEL_W-1:0]    slot_idx;
  logic                cnt_load_one;
  logic                cnt_clear;
  logic                cnt_advance;

  assign slot_zero = (count == '0);
  assign slot_idx  = count[SEL_W-1:0];
  assign sel       = count;

  tdm_slot_counter #(
    .W    (CNT_W),
    .LAST (FRAME_LEN - 1)
  ) u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (cnt_load_one),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .count    (count),
    .terminal (terminal)
  );

  // Counter control mirrors the FSM decisions: frame end has priority over
  // the sync check, a missing sync at slot 0 clears, a stray sync reloads.
  always_comb begin
    cnt_load_one = 1'b0;
    cnt_clear    = 1'b0;
    cnt_advance  = 1'b0;
    if (state == ST_HUNT) begin
      cnt_load_one = sync_in;
    end else if (terminal) begin
      cnt_advance = 1'b1;
    end else if (slot_zero && !sync_in) begin
      cnt_clear = 1'b1;
    end else if (!slot_zero && sync_in) begin
      cnt_load_one = 1'b1;
    end else begin
      cnt_advance = 1'b1;
    end
  end

  // Lock FSM, shadow staging register and registered frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      shadow      <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        ST_HUNT: begin
          if (sync_in) begin
            shadow[0] <= din;
            state     <= ST_RUN;
            locked    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (terminal) begin
`ifdef TDM_DEMUX_PARITY_EN
            if (din == (^shadow)) begin
              out         <= shadow;
              frame_valid <= 1'b1;
            end else begin
              parity_err  <= 1'b1;
            end
`else
            out         <= {din, shadow};
            frame_valid <= 1'b1;
`endif
          end else if (slot_zero && !sync_in) begin
            // Missing sync at slot 0: drop lock, keep the last good frame.
            state  <= ST_HUNT;
            locked <= 1'b0;
          end else if (sync_in) begin
            // Sync at slot 0 (normal) or mid-frame (resync): bit is slot 0.
            shadow[0] <= din;
          end else begin
            shadow[slot_idx] <= din;
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demultiplex.sv
// Self-checking bench for tdm_demultiplex (N=8). A frame-level reference model
// tracks lock, slot position and collected bits; a negedge process compares every
// output each cycle, and directed scenarios pin literal expected values.
module tb_tdm_demultiplex;

  localparam int N = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL    = N + 1;
  localparam int CNT_W = 4;
`else
  localparam int FL    = N;
  localparam int CNT_W = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sync_in = 1'b0;
  logic             din = 1'b0;
  logic [N-1:0]     out;
  logic             frame_valid;
  logic [CNT_W-1:0] sel;
  logic             locked;
  logic             perr_dut;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  tdm_demultiplex dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     (sync_in),
    .din         (din),
    .out         (out),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err  (perr_dut)
`endif
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign perr_dut = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_data = '0;
  logic         m_fv = 1'b0;
  logic         m_perr = 1'b0;
  logic         m_locked = 1'b0;
  int           m_pos = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_out = '0; m_data = '0; m_fv = 1'b0; m_perr = 1'b0;
      m_locked = 1'b0; m_pos = 0;
    end else begin
      m_fv = 1'b0;
      m_perr = 1'b0;
      if (!m_locked) begin
        if (sync_in) begin
          m_data[0] = din; m_pos = 1; m_locked = 1'b1;
        end
      end else if (m_pos == FL - 1) begin
`ifdef TDM_DEMUX_PARITY_EN
        if (din == (^m_data)) begin m_out = m_data; m_fv = 1'b1; end
        else m_perr = 1'b1;
`else
        m_data[N-1] = din;
        m_out = m_data;
        m_fv = 1'b1;
`endif
        m_pos = 0;
      end else if (m_pos == 0 && !sync_in) begin
        m_locked = 1'b0;
      end else if (sync_in) begin
        m_data[0] = din; m_pos = 1;
      end else begin
        m_data[m_pos] = din; m_pos++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out", 32'(out), 32'(m_out));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("sel", 32'(sel), 32'(m_pos));
      check("locked", 32'(locked), 32'(m_locked));
      check("parity_err", 32'(perr_dut), 32'(m_perr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic s, input logic d);
    sync_in = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame starting with sync; returns 1-based cycle of first frame_valid (0 if none).
  task automatic send_frame(input logic [N-1:0] v, input bit par_ok, output int fv_at);
    fv_at = 0;
    for (int i = 0; i < N; i++) begin
      cyc((i == 0), v[i]);
      if (frame_valid && fv_at == 0) fv_at = i + 1;
    end
`ifdef TDM_DEMUX_PARITY_EN
    cyc(1'b0, (^v) ^ !par_ok);
    if (frame_valid && fv_at == 0) fv_at = FL;
`else
    if (!par_ok) fv_at = -1;
`endif
  endtask

  int pos;

  initial begin
    #1 chk_en = 1'b1;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    check("hunt_ignores_din", 32'(locked), 32'h0);

    // 1. single frame 8'hAD
    send_frame(8'hAD, 1'b1, pos);
    check("t1_out", 32'(out), 32'hAD);
    check("t1_fv", 32'(frame_valid), 32'h1);
    check("t1_locked", 32'(locked), 32'h1);
    check("t1_fv_pos", 32'(pos), 32'(FL));

    // 3. lost lock at next slot 0, then relock with 8'h55
    cyc(1'b0, 1'b1);
    check("t3_unlocked", 32'(locked), 32'h0);
    check("t3_out_held", 32'(out), 32'hAD);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("t3_sel_hunt", 32'(sel), 32'h0);
    send_frame(8'h55, 1'b1, pos);
    check("t3_relock_out", 32'(out), 32'h55);
    check("t3_relock_pos", 32'(pos), 32'(FL));

    // 2. back-to-back 8'hAD, 8'h3C: pulses at FL and 2*FL after first sync
    send_frame(8'hAD, 1'b1, pos);
    check("t2_first_pos", 32'(pos), 32'(FL));
    check("t2_first_out", 32'(out), 32'hAD);
    send_frame(8'h3C, 1'b1, pos);
    check("t2_second_pos", 32'(pos), 32'(FL));
    check("t2_second_out", 32'(out), 32'h3C);

    // 4. resync at slot 4 mid-frame, then 8'hF0
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("t4_sel_before", 32'(sel), 32'h4);
    send_frame(8'hF0, 1'b1, pos);
    check("t4_no_abort_pulse", 32'(pos), 32'(FL));
    check("t4_out", 32'(out), 32'hF0);

    // 5. async reset at slot 5
    cyc(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0);
    check("t5_sel_before", 32'(sel), 32'h5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out", 32'(out), 32'h0);
    check("t5_rst_sel", 32'(sel), 32'h0);
    check("t5_rst_locked", 32'(locked), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("t5_hunt_locked", 32'(locked), 32'h0);
    send_frame(8'hA5, 1'b1, pos);
    check("t5_after_out", 32'(out), 32'hA5);

`ifdef TDM_DEMUX_PARITY_EN
    // 6. parity good then bad
    send_frame(8'hAD, 1'b1, pos);
    check("t6_good_out", 32'(out), 32'hAD);
    check("t6_good_fv", 32'(frame_valid), 32'h1);
    send_frame(8'h3C, 1'b0, pos);
    check("t6_bad_perr", 32'(perr_dut), 32'h1);
    check("t6_bad_fv", 32'(frame_valid), 32'h0);
    check("t6_bad_out_held", 32'(out), 32'hAD);
`endif

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
